// File: rtl/mult32_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult32_seq
// Description : Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add
//               multiplier. It has no adder of its own. The external alu32
//               does every partial-sum addition: this block drives the ALU
//               operands and consumes the ALU sum and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_s,
    input  logic                 alu_cout,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [2:0]     C_ADD  = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_p_hi;
    logic [WIDTH-1:0]    r_p_lo;
    logic [WIDTH-1:0]    r_m;
    logic [CW-1:0]       r_count;
    logic [WIDTH-1:0]    w_next_hi;
    logic [WIDTH-1:0]    w_next_lo;

    // The ALU always computes P_hi + M. The block only adds the multiplicand
    // in when the current multiplier bit is set.
    assign alu_a  = r_p_hi;
    assign alu_b  = r_m;
    assign alu_op = C_ADD;

    // Next value of one shift-add iteration. The ALU carry becomes the new
    // top bit, so no product bit is lost.
    always_comb begin
        w_next_hi = {1'b0, r_p_hi[WIDTH-1:1]};
        w_next_lo = {r_p_hi[0], r_p_lo[WIDTH-1:1]};
        if (r_p_lo[0]) begin
            {w_next_hi, w_next_lo} = {alu_cout, alu_s, r_p_lo[WIDTH-1:1]};
        end
    end

    // Control FSM and datapath registers. busy and done are registered
    // decodes of the state that is being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_m     <= '0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= multiplicand;
                        r_p_lo  <= multiplier;
                        r_p_hi  <= '0;
                        r_count <= '0;
                        r_state <= S_CALC;
                        busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_p_hi  <= w_next_hi;
                    r_p_lo  <= w_next_lo;
                    r_count <= r_count + CW'(1);
                    if (r_count == C_LAST) begin
                        // Capture the final iteration straight into the
                        // product so that it is valid together with done.
                        product <= {w_next_hi, w_next_lo};
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult32_seq
// Description : Directed self-checking bench for mult32_seq. The bench
//               provides a behavioural alu32 adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_s;
    logic        alu_cout;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int tests = 0;
    int fails = 0;

    mult32_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_s        (alu_s),
        .alu_cout     (alu_cout),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // Model of the upstream alu32 in add mode.
    assign {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the ALU op on the way.
    task automatic tick();
        @(negedge clk);
        check("alu_op", {61'd0, alu_op}, 64'd0);
    endtask

    // Single-pulse start, then check latency, busy length, result, done width.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int edges;
        int busy_cnt;
        bit got;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1234_5678;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        got      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            edges++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("done_seen", {63'd0, got}, 64'd1);
        check("latency", 64'(edges), 64'd33);
        check("busy_len", 64'(busy_cnt), 64'd32);
        check("product", product, exp);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        tick();
        check("done_width", {63'd0, done}, 64'd0);
        check("product_hold", product, exp);
    endtask

    initial begin
        int gap;
        bit got;
        bit spurious;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_alu_a", {32'd0, alu_a}, 64'd0);
        check("rst_alu_b", {32'd0, alu_b}, 64'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", {63'd0, busy}, 64'd0);

        run(32'h0000_0014, 32'h0000_0013, 64'h0000_0000_0000_017C);
        run(32'h0000_0A40, 32'h0000_0F13, 64'h0000_0000_009A_82C0);
        run(32'hF000_0C14, 32'h0000_0000, 64'h0000_0000_0000_0000);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF);

        // Start held high: expect repeated 42 with one done every 34 cycles.
        multiplicand = 32'd7;
        multiplier   = 32'd6;
        start        = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("held_first_done", {63'd0, got}, 64'd1);
        check("held_first_prod", product, 64'h2A);
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            gap++;
            // Corrupt the operands while the accepted operation is running.
            if (gap == 5)  begin multiplicand = 32'd9; multiplier = 32'd9; end
            if (gap == 25) begin multiplicand = 32'd7; multiplier = 32'd6; end
            if (gap > 1 && gap < 34) check("held_prod_stable", product, 64'h2A);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("held_second_done", {63'd0, got}, 64'd1);
        check("held_period", 64'(gap), 64'd34);
        check("held_second_prod", product, 64'h2A);
        start = 1'b0;
        tick();
        tick();
        tick();

        // Reset in the middle of an operation aborts it.
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        spurious = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) spurious = 1'b1;
        end
        check("abort_quiet", {63'd0, spurious}, 64'd0);
        run(32'h0001_0001, 32'h0000_FFFF, 64'h0000_0000_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
